// File: rtl/threshold_pack_engine_if.sv
// threshold_pack_engine_if: pixel beat stream into, and memory write bus out of, threshold_pack_engine.
interface threshold_pack_engine_if #(
  parameter int NUM_LANES = 4,
  parameter int OUT_W = 8
);
  logic [8*NUM_LANES-1:0] pix_data;
  logic pix_valid;
  logic pix_ready;
  logic [31:0] mem_addr;
  logic [OUT_W-1:0] mem_data_out;
  logic mem_en;
  logic mem_rw;
  logic mem_ack;
  modport master (
    input pix_data, pix_valid, mem_ack,
    output pix_ready, mem_addr, mem_data_out, mem_en, mem_rw
  );
  modport slave (
    output pix_data, pix_valid, mem_ack,
    input pix_ready, mem_addr, mem_data_out, mem_en, mem_rw
  );
endinterface

// File: rtl/threshold_pack_engine.sv
// threshold_pack_engine: binarises pixel beats against a per-frame threshold and packs the bits into memory write words.
// Define FG_COUNT_EN to add fg_count, the number of 1-bits produced in the current frame.
module threshold_pack_engine #(
  parameter int NUM_LANES = 4,
  parameter int OUT_W = 8,
  parameter int IMAGE_WIDTH = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [7:0] threshold,
  threshold_pack_engine_if.master bus,
  output logic busy,
  output logic done
`ifdef FG_COUNT_EN
  ,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] fg_count
`endif
);
  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int NUM_BEATS = TOTAL / NUM_LANES;
  localparam int BW = $clog2(NUM_BEATS + 1);
  localparam int FW = $clog2(OUT_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] thr_q, thr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [OUT_W-1:0] pack_q, pack_d, pack_next, mem_data_q, mem_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic mem_en_q, mem_en_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_LANES-1:0] bits;
  logic accept, acked, word_full, last_beat;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign bits[k] = bus.pix_data[8*k +: 8] > thr_q;
  end
  // mem_en doubles as the write-pending flag: no beat is taken while a word is outstanding
  assign accept = state_q == RUN && !mem_en_q && bus.pix_valid;
  assign acked = mem_en_q && bus.mem_ack;
  assign pack_next = pack_q | (OUT_W'(bits) << fill_q);
  assign word_full = fill_q == FW'(OUT_W - NUM_LANES);
  assign last_beat = beat_q == BW'(NUM_BEATS - 1);
  always_comb begin
    state_d = state_q;
    thr_d = thr_q;
    beat_d = beat_q;
    fill_d = fill_q;
    pack_d = pack_q;
    mem_data_d = mem_data_q;
    mem_addr_d = acked ? mem_addr_q + 32'(OUT_W / 8) : mem_addr_q;
    mem_en_d = mem_en_q && !bus.mem_ack;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      thr_d = threshold;
      beat_d = '0;
      fill_d = '0;
      pack_d = '0;
      mem_addr_d = BASE_ADDR;
    end
    if (accept) begin
      beat_d = beat_q + BW'(1);
      fill_d = word_full ? '0 : fill_q + FW'(NUM_LANES);
      pack_d = word_full ? '0 : pack_next;
      mem_data_d = word_full ? pack_next : mem_data_q;
      mem_en_d = word_full;
      state_d = last_beat ? FLUSH : state_q;
    end
    if (state_q == FLUSH && acked) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
`ifdef FG_COUNT_EN
  logic [$clog2(TOTAL+1)-1:0] fg_q, fg_d;
  always_comb begin
    fg_d = state_q == IDLE && start ? '0 : fg_q;
    fg_d = accept ? fg_q + $bits(fg_q)'($countones(bits)) : fg_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fg_q <= '0;
    else fg_q <= fg_d;
  end
  assign fg_count = fg_q;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      thr_q <= '0;
      beat_q <= '0;
      fill_q <= '0;
      pack_q <= '0;
      mem_data_q <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q <= thr_d;
      beat_q <= beat_d;
      fill_q <= fill_d;
      pack_q <= pack_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q <= mem_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.pix_ready = state_q == RUN && !mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_rw = mem_en_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_threshold_pack_engine.sv
// tb_threshold_pack_engine: directed vector bench for threshold_pack_engine at default parameters.
module tb_threshold_pack_engine;
  localparam logic [31:0] BASE = 32'h0010_0000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic busy, done;
  int tests = 0;
  int failed = 0;
  int done_cnt = 0;
  int bad;
  logic [31:0] wr_addr[$];
  logic [7:0] wr_data[$];
  typedef struct {logic [31:0] b0; logic [31:0] b1; logic [7:0] exp;} vec_t;
  vec_t vec[6];
  threshold_pack_engine_if #(.NUM_LANES(4), .OUT_W(8)) bus ();
`ifdef FG_COUNT_EN
  logic [12:0] fg_count;
`endif
  threshold_pack_engine dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .threshold(threshold),
    .bus(bus),
    .busy(busy),
    .done(done)
`ifdef FG_COUNT_EN
    ,
    .fg_count(fg_count)
`endif
  );
  always #5 clk = ~clk;
  // a write completes in any cycle where mem_en and mem_ack are both high
  always @(negedge clk) begin
    if (bus.mem_en && bus.mem_ack) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data_out);
    end
    if (done) done_cnt++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send_beat(input logic [31:0] d);
    int t = 0;
    bus.pix_data = d;
    bus.pix_valid = 1'b1;
    @(negedge clk);
    while (!bus.pix_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.pix_ready) check("beat_timeout", 32'(bus.pix_ready), 32'd1);
    @(posedge clk);
    #1 bus.pix_valid = 1'b0;
  endtask
  task automatic do_start(input logic [7:0] thr);
    @(posedge clk);
    #1 start = 1'b1;
    threshold = thr;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{32'h9632_6564, 32'hC8C8_C8C8, 8'hFA};
    vec[1] = '{32'h6464_6464, 32'h6565_6565, 8'hF0};
    vec[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 8'h0F};
    vec[3] = '{32'hC800_C800, 32'h00C8_00C8, 8'h5A};
    vec[4] = '{32'h0102_0304, 32'h6465_6465, 8'h50};
    vec[5] = '{32'h807F_807F, 32'hFF00_0000, 8'h8F};
    bus.pix_data = '0;
    bus.pix_valid = 1'b0;
    bus.mem_ack = 1'b0;
    #12;
    check("rst_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", bus.mem_addr, BASE);
    check("rst_data", 32'(bus.mem_data_out), 32'd0);
`ifdef FG_COUNT_EN
    check("rst_fg", 32'(fg_count), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    bus.mem_ack = 1'b1;
    bus.pix_data = '1;
    bus.pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.pix_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 bus.pix_valid = 1'b0;
    check("idle_writes", 32'(wr_data.size()), 32'd0);
    // frame A: table vectors, then a threshold change and restart attempt mid-frame
    do_start(8'd100);
    threshold = 8'd0;
    check("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      send_beat(vec[i].b0);
      if (i == 0) check("en_after_beat1", 32'(bus.mem_en), 32'd0);
      send_beat(vec[i].b1);
      if (i == 0) begin
        check("en_after_beat2", 32'(bus.mem_en), 32'd1);
        check("rw_after_beat2", 32'(bus.mem_rw), 32'd1);
        check("first_addr", bus.mem_addr, BASE);
        check("first_word", 32'(bus.mem_data_out), 32'h0000_00FA);
      end
    end
    @(posedge clk);
    #1 start = 1'b1;
    threshold = 8'd255;
    @(posedge clk);
    #1 start = 1'b0;
    check("restart_ignored_busy", 32'(busy), 32'd1);
    for (int i = 12; i < 1024; i++) send_beat(32'hC8C8_C8C8);
    wait_done(0);
    check("a_done_once", 32'(done_cnt), 32'd1);
    check("a_busy_after", 32'(busy), 32'd0);
    check("a_done_after", 32'(done), 32'd0);
    check("a_write_count", 32'(wr_data.size()), 32'd512);
    for (int i = 0; i < 6; i++) check("a_table_word", 32'(wr_data[i]), 32'(vec[i].exp));
    bad = 0;
    for (int i = 6; i < wr_data.size(); i++) if (wr_data[i] !== 8'hFF) bad++;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] !== BASE + 32'(i)) bad++;
    check("a_bulk_words_addrs", 32'(bad), 32'd0);
    check("a_last_addr", wr_addr[511], 32'h0010_01FF);
    // frame B: stalled first write, then reset mid-frame
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    bus.mem_ack = 1'b0;
    do_start(8'd100);
    send_beat(32'hC8C8_C8C8);
    send_beat(32'hC8C8_C8C8);
    bus.pix_data = '0;
    bus.pix_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_en", 32'(bus.mem_en), 32'd1);
      check("stall_addr", bus.mem_addr, BASE);
      check("stall_data", 32'(bus.mem_data_out), 32'h0000_00FF);
      check("stall_ready", 32'(bus.pix_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.mem_ack = 1'b1;
    @(negedge clk);
    check("ack_cycle_en", 32'(bus.mem_en), 32'd1);
    @(negedge clk);
    check("resume_en", 32'(bus.mem_en), 32'd0);
    check("resume_ready", 32'(bus.pix_ready), 32'd1);
    check("resume_addr", bus.mem_addr, BASE + 32'd1);
    @(posedge clk);
    #1 bus.pix_valid = 1'b0;
    for (int i = 3; i < 100; i++) send_beat(32'hC8C8_C8C8);
    check("pre_reset_en", 32'(bus.mem_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_en", 32'(bus.mem_en), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_ready", 32'(bus.pix_ready), 32'd0);
    check("mid_reset_addr", bus.mem_addr, BASE);
    check("b_write_count", 32'(wr_data.size()), 32'd49);
    check("b_second_word", 32'(wr_data[1]), 32'h0000_00F0);
    check("b_second_addr", wr_addr[1], BASE + 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    check("b_no_done", 32'(done_cnt), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_ready", 32'(bus.pix_ready), 32'd0);
    // frame C: checkerboard 0/255 at threshold 127
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    do_start(8'd127);
`ifdef FG_COUNT_EN
    check("c_fg_cleared", 32'(fg_count), 32'd0);
`endif
    for (int r = 0; r < 64; r++)
      for (int b = 0; b < 16; b++) send_beat(r[0] ? 32'h00FF_00FF : 32'hFF00_FF00);
    wait_done(0);
    check("c_done_once", 32'(done_cnt), 32'd1);
    check("c_write_count", 32'(wr_data.size()), 32'd512);
    check("c_first_addr", wr_addr[0], BASE);
    check("c_even_row_word", 32'(wr_data[0]), 32'h0000_00AA);
    check("c_odd_row_word", 32'(wr_data[8]), 32'h0000_0055);
    check("c_last_addr", wr_addr[511], 32'h0010_01FF);
`ifdef FG_COUNT_EN
    check("c_fg_count", 32'(fg_count), 32'd2048);
    repeat (5) @(negedge clk);
    check("c_fg_held", 32'(fg_count), 32'd2048);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
